fp_mul_seq: RTL



---
 rtl/fp_mul_seq_if.sv | 23 ++
 rtl/fp_mul_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_if.sv
// Start/done handshake bundle between the operand router, fp_mul_seq and the FPU result mux.
// Signal names follow the multiplier's port list; clk and rst_n stay on the module.
interface fp_mul_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  modport master (
    output start, a, b,
    input  busy, done, result, overflow, underflow, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle binary32 multiplier: radix-2 shift-add significand product, then normalise and
// round-to-nearest-even. Every operand class takes the same 27-cycle start-to-done path.
module fp_mul_seq #(
  parameter int          MANT_W   = 24,
  parameter int          EXP_BIAS = 127,
  parameter logic [31:0] QNAN     = 32'h7FC00000
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  typedef enum logic [1:0] {IDLE, MULT, NORM, ROUND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mcand_q, mcand_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [MANT_W-1:0]   sig_q, sig_d;
  logic                guard_q, guard_d;
  logic                rnd_q, rnd_d;
  logic                sticky_q, sticky_d;
  logic                anyNan_q, anyNan_d;
  logic                anyInf_q, anyInf_d;
  logic                anyZero_q, anyZero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         result_q, result_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                invalid_q, invalid_d;

  logic [7:0]          expA, expB;
  logic [FRAC_W-1:0]   fracA, fracB;
  logic                zeroA, zeroB, infA, infB, nanA, nanB;
  logic [MANT_W-1:0]   manA, manB;
  logic signed [9:0]   expSum;
  logic [MANT_W:0]     partial;
  logic                roundUp;
  logic [MANT_W:0]     sigRnd;
  logic signed [9:0]   expFin;
  logic [FRAC_W-1:0]   fracFin;

  // Denormal inputs (exp=0) are treated as signed zero, so their significand is dropped.
  assign expA   = bus.a[30:23];
  assign expB   = bus.b[30:23];
  assign fracA  = bus.a[FRAC_W-1:0];
  assign fracB  = bus.b[FRAC_W-1:0];
  assign zeroA  = (expA == 8'h00);
  assign zeroB  = (expB == 8'h00);
  assign infA   = (expA == 8'hFF) && (fracA == '0);
  assign infB   = (expB == 8'hFF) && (fracB == '0);
  assign nanA   = (expA == 8'hFF) && (fracA != '0);
  assign nanB   = (expB == 8'hFF) && (fracB != '0);
  assign manA   = zeroA ? '0 : {1'b1, fracA};
  assign manB   = zeroB ? '0 : {1'b1, fracB};
  assign expSum = $signed({2'b00, expA}) + $signed({2'b00, expB}) - $signed(10'(EXP_BIAS));

  // The multiplier sits in the low half of the accumulator and is consumed LSB-first.
  assign partial = {1'b0, acc_q[PROD_W-1:MANT_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  assign roundUp = guard_q & (rnd_q | sticky_q | sig_q[0]);
  assign sigRnd  = {1'b0, sig_q} + {{MANT_W{1'b0}}, roundUp};
  assign expFin  = exp_q + (sigRnd[MANT_W] ? 10'sd1 : 10'sd0);
  assign fracFin = sigRnd[MANT_W] ? sigRnd[MANT_W-1:1] : sigRnd[FRAC_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    guard_d     = guard_q;
    rnd_d       = rnd_q;
    sticky_d    = sticky_q;
    anyNan_d    = anyNan_q;
    anyInf_d    = anyInf_q;
    anyZero_d   = anyZero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    invalid_d   = invalid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d   = manA;
          acc_d     = {{MANT_W{1'b0}}, manB};
          sign_d    = bus.a[31] ^ bus.b[31];
          exp_d     = expSum;
          anyNan_d  = nanA | nanB;
          anyInf_d  = infA | infB;
          anyZero_d = zeroA | zeroB;
          cnt_d     = CNT_W'(MANT_W);
          busy_d    = 1'b1;
          state_d   = MULT;
        end
      end

      MULT: begin
        acc_d = {partial, acc_q[MANT_W-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = NORM;
        end
      end

      NORM: begin
        if (acc_q[PROD_W-1]) begin
          sig_d    = acc_q[PROD_W-1 -: MANT_W];
          guard_d  = acc_q[MANT_W-1];
          rnd_d    = acc_q[MANT_W-2];
          sticky_d = |acc_q[MANT_W-3:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          sig_d    = acc_q[PROD_W-2 -: MANT_W];
          guard_d  = acc_q[MANT_W-2];
          rnd_d    = acc_q[MANT_W-3];
          sticky_d = |acc_q[MANT_W-4:0];
        end
        state_d = ROUND;
      end

      ROUND: begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        invalid_d   = 1'b0;
        // Special operands override the datapath result; earlier branches take priority.
        if (anyNan_q || (anyInf_q && anyZero_q)) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
        end else if (anyInf_q) begin
          result_d = {sign_q, 8'hFF, {FRAC_W{1'b0}}};
        end else if (anyZero_q) begin
          result_d = {sign_q, 31'h0};
        end else if (expFin >= 10'sd255) begin
          result_d   = {sign_q, 8'hFF, {FRAC_W{1'b0}}};
          overflow_d = 1'b1;
        end else if (expFin <= 10'sd0) begin
          result_d    = {sign_q, 31'h0};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_q, expFin[7:0], fracFin};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      guard_q     <= 1'b0;
      rnd_q       <= 1'b0;
      sticky_q    <= 1'b0;
      anyNan_q    <= 1'b0;
      anyInf_q    <= 1'b0;
      anyZero_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'h0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      guard_q     <= guard_d;
      rnd_q       <= rnd_d;
      sticky_q    <= sticky_d;
      anyNan_q    <= anyNan_d;
      anyInf_q    <= anyInf_d;
      anyZero_q   <= anyZero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      invalid_q   <= invalid_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.invalid   = invalid_q;

endmodule
